dispatch_queue: RTL and testbench

DISPATCH_QUEUE -- requirements
Module: dispatch_queue

---
 rtl/dispatch_queue_if.sv | 40 ++++
 rtl/dispatch_queue.sv | 65 ++++++
 tb/tb_dispatch_queue.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: shared instruction types plus the rename/issue/writeback bundle of the dispatch queue
package dispatch_pkg;
  localparam int PRFSIZE = 32;
  typedef logic [$clog2(PRFSIZE)-1:0] preg_id_t;
  typedef struct packed {
    logic rs1_valid;
    logic rs2_valid;
    logic rd_valid;
  } src_info_t;
  typedef struct packed {
    logic [7:0] id;
    src_info_t  si;
    preg_id_t   prs1;
    preg_id_t   prs2;
    preg_id_t   prd;
    logic       prs1_renammed;
    logic       prs2_renammed;
  } di_t;
endpackage

interface dispatch_queue_if #(parameter int DEPTH = 4);
  import dispatch_pkg::*;
  di_t                    di_i;
  logic                   di_i_valid;
  logic                   di_i_ready;
  di_t                    di_o;
  logic                   di_o_valid;
  logic                   di_o_ready;
  logic                   wb_valid;
  preg_id_t               wb_prd;
  logic [$clog2(DEPTH):0] count_o;
  modport slave (
    input  di_i, di_i_valid, di_o_ready, wb_valid, wb_prd,
    output di_i_ready, di_o, di_o_valid, count_o
  );
  modport master (
    output di_i, di_i_valid, di_o_ready, wb_valid, wb_prd,
    input  di_i_ready, di_o, di_o_valid, count_o
  );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order dispatch FIFO with a register-readiness scoreboard; define DISPATCH_WB_BYPASS_EN for same-cycle writeback wakeup
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  dispatch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  di_t                mem [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [AW:0]        count;
  logic [PRFSIZE-1:0] sb;
  logic [PRFSIZE-1:0] sb_next;
  logic               empty;
  logic               enq;
  logic               deq;
  logic               rdy1;
  logic               rdy2;
  logic               byp1;
  logic               byp2;
`ifdef DISPATCH_WB_BYPASS_EN
  assign byp1 = bus.wb_valid && bus.wb_prd == mem[head].prs1;
  assign byp2 = bus.wb_valid && bus.wb_prd == mem[head].prs2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  assign empty          = count == '0;
  assign rdy1           = !mem[head].si.rs1_valid || !mem[head].prs1_renammed || sb[mem[head].prs1] || byp1;
  assign rdy2           = !mem[head].si.rs2_valid || !mem[head].prs2_renammed || sb[mem[head].prs2] || byp2;
  assign bus.di_i_ready = !rst && count != (AW+1)'(DEPTH);
  assign bus.di_o_valid = !rst && !empty && rdy1 && rdy2;
  assign bus.di_o       = mem[head];
  assign bus.count_o    = count;
  assign enq            = bus.di_i_valid && bus.di_i_ready;
  assign deq            = bus.di_o_valid && bus.di_o_ready;
  // next scoreboard: writeback sets, then an enqueue reallocating the same register clears
  always_comb begin
    sb_next = sb;
    if (bus.wb_valid) sb_next[bus.wb_prd] = 1'b1;
    if (enq && bus.di_i.si.rd_valid) sb_next[bus.di_i.prd] = 1'b0;
  end
  // pointers, occupancy and scoreboard; reset overrides any in-flight event
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      sb    <= '1;
    end else begin
      head  <= deq ? head + 1'b1 : head;
      tail  <= enq ? tail + 1'b1 : tail;
      count <= (enq && !deq) ? count + 1'b1 : (deq && !enq) ? count - 1'b1 : count;
      sb    <= sb_next;
    end
  end
  // entry storage is written only on enqueue and never modified while queued
  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= bus.di_i;
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed scoreboard bench for dispatch_queue
module tb_dispatch_queue;
  import dispatch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_q [$];
  dispatch_queue_if #(.DEPTH(4)) bus ();
  dispatch_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic di_t mk(input logic [7:0] id, input logic rs1v, input preg_id_t prs1,
                             input logic ren1, input logic rdv, input preg_id_t prd);
    di_t d;
    d = '0;
    d.id = id;
    d.si.rs1_valid = rs1v;
    d.prs1 = prs1;
    d.prs1_renammed = ren1;
    d.si.rd_valid = rdv;
    d.prd = prd;
    return d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input di_t d);
    bus.di_i = d;
    bus.di_i_valid = 1'b1;
    exp_q.push_back(d.id);
  endtask

  // monitor: every accepted issue must match the oldest expected id
  always @(negedge clk) begin
    if (!rst && bus.di_o_valid && bus.di_o_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL issue_unexpected: got id %0d expected none", bus.di_o.id);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.di_o.id != e) begin
          bad++;
          $display("FAIL issue_order: got id %0d expected %0d", bus.di_o.id, e);
        end
      end
    end
  end

  initial begin
    bus.di_i = '0;
    bus.di_i_valid = 1'b0;
    bus.di_o_ready = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_prd = '0;
    step();
    chk("rst_ready", int'(bus.di_i_ready), 0);
    chk("rst_valid", int'(bus.di_o_valid), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(bus.di_i_ready), 1);
    chk("post_rst_valid", int'(bus.di_o_valid), 0);
    chk("post_rst_count", int'(bus.count_o), 0);
    // no fall-through
    push(mk(8'd1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0));
    #1;
    chk("no_fallthrough", int'(bus.di_o_valid), 0);
    step();
    bus.di_i_valid = 1'b0;
    chk("visible_next", int'(bus.di_o_valid), 1);
    bus.di_o_ready = 1'b1;
    step();
    bus.di_o_ready = 1'b0;
    chk("count_after_deq", int'(bus.count_o), 0);
    // fill to DEPTH
    for (int i = 0; i < 4; i++) begin
      push(mk(8'(2 + i), 1'b0, 5'd0, 1'b0, 1'b0, 5'd0));
      step();
    end
    bus.di_i_valid = 1'b0;
    chk("full_ready", int'(bus.di_i_ready), 0);
    chk("full_count", int'(bus.count_o), 4);
    bus.di_i = mk(8'd99, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    bus.di_i_valid = 1'b1;
    bus.di_o_ready = 1'b1;
    #1;
    chk("full_deq_ready", int'(bus.di_i_ready), 0);
    step();
    bus.di_i_valid = 1'b0;
    chk("after_deq_ready", int'(bus.di_i_ready), 1);
    chk("after_deq_count", int'(bus.count_o), 3);
    repeat (3) step();
    bus.di_o_ready = 1'b0;
    chk("drained_count", int'(bus.count_o), 0);
    // dependency: B waits on A's destination p5
    push(mk(8'd7, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5));
    step();
    push(mk(8'd8, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0));
    step();
    bus.di_i_valid = 1'b0;
    bus.di_o_ready = 1'b1;
    step();
    chk("dep_wait", int'(bus.di_o_valid), 0);
    step();
    chk("dep_wait2", int'(bus.di_o_valid), 0);
    bus.wb_valid = 1'b1;
    bus.wb_prd = 5'd5;
    #1;
`ifdef DISPATCH_WB_BYPASS_EN
    chk("dep_wake_T", int'(bus.di_o_valid), 1);
`else
    chk("dep_wake_T", int'(bus.di_o_valid), 0);
`endif
    step();
    bus.wb_valid = 1'b0;
`ifdef DISPATCH_WB_BYPASS_EN
    chk("dep_wake_T1", int'(bus.count_o), 0);
`else
    chk("dep_wake_T1", int'(bus.di_o_valid), 1);
`endif
    step();
    bus.di_o_ready = 1'b0;
    chk("dep_count", int'(bus.count_o), 0);
    // simultaneous clear and set on p7: clear wins
    push(mk(8'd9, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7));
    bus.wb_valid = 1'b1;
    bus.wb_prd = 5'd7;
    step();
    bus.wb_valid = 1'b0;
    push(mk(8'd10, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0));
    step();
    bus.di_i_valid = 1'b0;
    bus.di_o_ready = 1'b1;
    step();
    chk("clear_wins", int'(bus.di_o_valid), 0);
    chk("clear_wins_count", int'(bus.count_o), 1);
    bus.wb_valid = 1'b1;
    bus.wb_prd = 5'd7;
    step();
    bus.wb_valid = 1'b0;
    step();
    chk("clear_drain_count", int'(bus.count_o), 0);
    // wrap-around with simultaneous enqueue/dequeue
    for (int i = 0; i < 10; i++) begin
      push(mk(8'(20 + i), 1'b0, 5'd0, 1'b0, 1'b0, 5'd0));
      step();
      if (i == 5) chk("wrap_count", int'(bus.count_o), 1);
    end
    bus.di_i_valid = 1'b0;
    step();
    chk("wrap_final_count", int'(bus.count_o), 0);
    bus.di_o_ready = 1'b0;
    step();
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
